xst: RTL

Serial transmit shift register; the transmit-side counterpart of the `xsr` receiver. A parallel word of up to `SHIFT_REG_WIDTH` bits is loaded through one of two write strobes (natural or bit-reversed order). It is then shifted out LSB first on `txd_o` at a programmable bit rate, with an accompanying `txc_o` strobe whose rising edge falls at mid-bit. Framing (start, parity and stop bits) is pre-formatted by software in the loaded word; the block only serialises.

---
 rtl/xst_pkg.sv | 10 +
 rtl/xs_baudgen.sv | 42 ++++
 rtl/xst.sv | 88 ++++++++
 3 files changed

// File: rtl/xst_pkg.sv
// Shared constants for the xs serial blocks (xst transmitter, xsr receiver).
package xst_pkg;

  localparam int XS_WIDTH      = 64;
  localparam int XS_BITS_W     = 6;
  localparam int XS_FRAME_8N1  = 10;
  localparam int XS_FRAME_8O1  = 11;
  localparam int XS_FRAME_8O2  = 12;

endpackage

// File: rtl/xs_baudgen.sv
// Loadable bit-period down-counter: tick_o marks the last clock of a bit,
// half_o is high during the second half of the bit.
module xs_baudgen #(
  parameter int W = 64
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         load_i,
  input  logic         run_i,
  input  logic [W-1:0] div_i,
  output logic         tick_o,
  output logic         half_o
);

  logic [W-1:0] dcnt_q, dcnt_d;
  logic [W-1:0] div_q, div_d;

  assign tick_o = (dcnt_q == '0);
  assign half_o = (dcnt_q <= (div_q >> 1));

  always_comb begin
    dcnt_d = dcnt_q;
    div_d  = div_q;
    if (load_i) begin
      div_d  = div_i;
      dcnt_d = div_i;
    end else if (run_i) begin
      dcnt_d = tick_o ? div_q : dcnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      dcnt_q <= '0;
      div_q  <= '0;
    end else begin
      dcnt_q <= dcnt_d;
      div_q  <= div_d;
    end
  end

endmodule

// File: rtl/xst.sv
// Serial transmit shift register: loads a pre-framed word and shifts it out
// LSB first with a mid-bit rising txc_o strobe.
module xst
  import xst_pkg::*;
#(
  parameter int SHIFT_REG_WIDTH = XS_WIDTH
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [XS_BITS_W-1:0]       bits_i,
  input  logic [SHIFT_REG_WIDTH-1:0] baud_i,
  input  logic [SHIFT_REG_WIDTH-1:0] dat_i,
  input  logic                       txreg_we_i,
  input  logic                       txregr_we_i,
  output logic                       txd_o,
  output logic                       txc_o,
  output logic                       idle_o
);

  localparam int W = SHIFT_REG_WIDTH;

  logic [W-1:0]         sr_q, sr_d;
  logic [XS_BITS_W-1:0] bcnt_q, bcnt_d;
  logic                 busy_q, busy_d;
  logic                 tick, half;
  logic                 last_bit, accept;
  logic [W-1:0]         dat_rev, load_data;

  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_rev
      assign dat_rev[gi] = dat_i[W-1-gi];
    end
  endgenerate

  assign load_data = txreg_we_i ? dat_i : dat_rev;
  assign last_bit  = busy_q && tick && (bcnt_q == XS_BITS_W'(1));
  // Accepting on the final clock of a frame lets frames run back-to-back.
  assign accept    = (!busy_q || last_bit) && (txreg_we_i || txregr_we_i)
                     && (bits_i != '0);

  xs_baudgen #(.W(W)) u_baudgen (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .load_i  (accept),
    .run_i   (busy_q && !accept),
    .div_i   (baud_i),
    .tick_o  (tick),
    .half_o  (half)
  );

  always_comb begin
    sr_d   = sr_q;
    bcnt_d = bcnt_q;
    busy_d = busy_q;
    if (accept) begin
      sr_d   = load_data;
      bcnt_d = bits_i;
      busy_d = 1'b1;
    end else if (busy_q && tick) begin
      if (bcnt_q > XS_BITS_W'(1)) begin
        sr_d   = {1'b1, sr_q[W-1:1]};
        bcnt_d = bcnt_q - 1'b1;
      end else begin
        sr_d   = '1;
        bcnt_d = '0;
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sr_q   <= '1;
      bcnt_q <= '0;
      busy_q <= 1'b0;
    end else begin
      sr_q   <= sr_d;
      bcnt_q <= bcnt_d;
      busy_q <= busy_d;
    end
  end

  assign txd_o  = sr_q[0];
  assign txc_o  = busy_q && half;
  assign idle_o = !busy_q;

endmodule
